match_controller: RTL and testbench

//  Sequences a CyberWar match around the play_light field and score path.

---
 rtl/cyberwar_pkg.sv | 18 +
 rtl/hold_timer.sv | 35 +++
 rtl/match_controller.sv | 141 ++++++++++++++
 tb/tb_match_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cyberwar_pkg.sv
// Shared types and constants for the CyberWar match sequencing logic.
package cyberwar_pkg;

  localparam int unsigned DiffW = 9;

  typedef enum logic [2:0] {
    StIdle,
    StServe,
    StPlay,
    StHold,
    StOver
  } match_state_e;

  localparam logic [1:0] WinNone  = 2'b00;
  localparam logic [1:0] WinCom   = 2'b01;
  localparam logic [1:0] WinHuman = 2'b10;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module hold_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             done
);

  logic [Width-1:0] count_q, count_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/match_controller.sv
// Match sequencer: serve, play, hold-after-point and game-over handling, with score keeping
// and a saturating computer threshold ramp driven by human points.
module match_controller #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned DIFF_STEP   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic [8:0] base_diff,
  output logic       field_reset,
  output logic       play_en,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [8:0] difficulty,
  output logic       match_over,
  output logic [1:0] winner
);

  import cyberwar_pkg::*;

  localparam int unsigned HoldW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [2:0]  WinScore = 3'(WIN_SCORE);
  // Loading HOLD_CYCLES-1 makes done coincide with the last hold cycle.
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
  localparam logic [DiffW:0]   DiffStep = (DIFF_STEP + 1 > (1 << DiffW)) ?
                                          (DiffW+1)'(1 << DiffW) : (DiffW+1)'(DIFF_STEP);

  match_state_e     state_q, state_d;
  logic [2:0]       p1_q, p1_d, p2_q, p2_d;
  logic [DiffW-1:0] diff_q, diff_d;
  logic [1:0]       winner_q, winner_d;
  logic             field_reset_q, play_en_q, match_over_q;
  logic             hold_load, hold_done;
  logic [2:0]       p1_inc, p2_inc;
  logic [DiffW:0]   diff_sum;

  hold_timer #(
    .Width(HoldW)
  ) u_hold_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .load_value(HoldLoad),
    .done      (hold_done)
  );

  assign p1_inc   = p1_q + 3'd1;
  assign p2_inc   = p2_q + 3'd1;
  assign diff_sum = {1'b0, diff_q} + DiffStep;

  // Next-state and score/threshold update.
  always_comb begin
    state_d   = state_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    diff_d    = diff_q;
    winner_d  = winner_q;
    hold_load = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d  = StServe;
          p1_d     = 3'd0;
          p2_d     = 3'd0;
          diff_d   = base_diff;
          winner_d = WinNone;
        end
      end
      StServe: state_d = StPlay;
      StPlay: begin
        if (p1_point && p2_point) begin
          // Simultaneous points: replay without scoring.
          state_d   = StHold;
          hold_load = 1'b1;
        end else if (p1_point) begin
          p1_d = p1_inc;
          if (p1_inc == WinScore) begin
            state_d  = StOver;
            winner_d = WinCom;
          end else begin
            state_d   = StHold;
            hold_load = 1'b1;
          end
        end else if (p2_point) begin
          p2_d   = p2_inc;
          diff_d = diff_sum[DiffW] ? {DiffW{1'b1}} : diff_sum[DiffW-1:0];
          if (p2_inc == WinScore) begin
            state_d  = StOver;
            winner_d = WinHuman;
          end else begin
            state_d   = StHold;
            hold_load = 1'b1;
          end
        end
      end
      StHold: begin
        if (hold_done) begin
          state_d = StServe;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, score and registered output flags; flags follow the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      p1_q          <= 3'd0;
      p2_q          <= 3'd0;
      diff_q        <= base_diff;
      winner_q      <= WinNone;
      field_reset_q <= 1'b1;
      play_en_q     <= 1'b0;
      match_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      diff_q        <= diff_d;
      winner_q      <= winner_d;
      field_reset_q <= (state_d != StPlay);
      play_en_q     <= (state_d == StPlay);
      match_over_q  <= (state_d == StOver);
    end
  end

  // Reset holds the field immediately; play_en is masked alongside so the two never overlap.
  assign field_reset = field_reset_q | ~reset;
  assign play_en     = play_en_q & reset;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign difficulty  = diff_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: a behavioural model pushes the expected outputs for
// every driven cycle, and they are popped and compared once the DUT has clocked.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset, start, p1_point, p2_point;
  logic [8:0] base_diff;
  logic       field_reset, play_en, match_over;
  logic [2:0] p1_score, p2_score;
  logic [8:0] difficulty;
  logic [1:0] winner;

  match_controller #(
    .WIN_SCORE  (7),
    .HOLD_CYCLES(4),
    .DIFF_STEP  (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .p1_point   (p1_point),
    .p2_point   (p2_point),
    .base_diff  (base_diff),
    .field_reset(field_reset),
    .play_en    (play_en),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .difficulty (difficulty),
    .match_over (match_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fr;
    logic       pe;
    logic [2:0] p1;
    logic [2:0] p2;
    logic [8:0] diff;
    logic       mo;
    logic [1:0] win;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: 0 idle, 1 serve, 2 play, 3 hold, 4 over.
  int m_st = 0, m_p1 = 0, m_p2 = 0, m_diff = 0, m_win = 0, m_hc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit a, input bit b,
                            input int base);
    if (!rst) begin
      m_st = 0; m_p1 = 0; m_p2 = 0; m_diff = base; m_win = 0;
    end else begin
      case (m_st)
        0, 4: if (st) begin
          m_st = 1; m_p1 = 0; m_p2 = 0; m_diff = base; m_win = 0;
        end
        1: m_st = 2;
        2: begin
          if (a && b) begin
            m_st = 3; m_hc = 0;
          end else if (a) begin
            m_p1 = m_p1 + 1;
            if (m_p1 == 7) begin m_st = 4; m_win = 1; end
            else begin m_st = 3; m_hc = 0; end
          end else if (b) begin
            m_p2 = m_p2 + 1;
            m_diff = (m_diff + 32 > 511) ? 511 : m_diff + 32;
            if (m_p2 == 7) begin m_st = 4; m_win = 2; end
            else begin m_st = 3; m_hc = 0; end
          end
        end
        3: begin
          m_hc = m_hc + 1;
          if (m_hc == 4) m_st = 1;
        end
        default: m_st = 0;
      endcase
    end
  endtask

  // One clock: drive at negedge, push expectation, clock, pop and compare at next negedge.
  task automatic step(input bit rst, input bit st, input bit a, input bit b, input int base);
    exp_t e;
    reset     = rst;
    start     = st;
    p1_point  = a;
    p2_point  = b;
    base_diff = 9'(base);
    model_step(rst, st, a, b, base);
    e.fr   = (m_st != 2);
    e.pe   = (m_st == 2);
    e.p1   = 3'(m_p1);
    e.p2   = 3'(m_p2);
    e.diff = 9'(m_diff);
    e.mo   = (m_st == 4);
    e.win  = 2'(m_win);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("field_reset", 32'(field_reset), 32'(e.fr));
    check("play_en", 32'(play_en), 32'(e.pe));
    check("p1_score", 32'(p1_score), 32'(e.p1));
    check("p2_score", 32'(p2_score), 32'(e.p2));
    check("difficulty", 32'(difficulty), 32'(e.diff));
    check("match_over", 32'(match_over), 32'(e.mo));
    check("winner", 32'(winner), 32'(e.win));
    check("exclusive", 32'(field_reset & play_en), 32'd0);
  endtask

  // Idle cycles with optional stray pulses, stopping once the model is in PLAY.
  task automatic wait_play(input int base, input bit noise);
    int n = 0;
    while (m_st != 2 && n < 12) begin
      step(1'b1, 1'b0, noise & $urandom_range(0, 1) == 1, noise & $urandom_range(0, 1) == 1,
           base);
      n++;
    end
    check("wait_play_bound", 32'(m_st == 2), 32'd1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; p1_point = 1'b0; p2_point = 1'b0; base_diff = 9'd100;
    @(negedge clk);

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 100);
    check("rst_difficulty", 32'(difficulty), 32'd100);
    check("rst_field_reset", 32'(field_reset), 32'd1);

    // Start, single serve cycle, then a human point
    step(1'b1, 1'b0, 1'b0, 1'b0, 100);
    step(1'b1, 1'b1, 1'b0, 1'b0, 100);
    check("serve_play_en", 32'(play_en), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 100);
    check("play_en_after_serve", 32'(play_en), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 100); // start ignored in PLAY
    step(1'b1, 1'b0, 1'b0, 1'b1, 100);
    check("p2_first_point", 32'(p2_score), 32'd1);
    check("diff_ramp", 32'(difficulty), 32'd132);
    wait_play(100, 1'b0);

    // Simultaneous points replay, stray pulses during hold/serve
    step(1'b1, 1'b0, 1'b1, 1'b1, 100);
    check("tie_p1", 32'(p1_score), 32'd0);
    check("tie_p2", 32'(p2_score), 32'd1);
    wait_play(100, 1'b1);

    // Computer wins
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 100);
      if (i < 6) wait_play(100, 1'b0);
    end
    check("com_score", 32'(p1_score), 32'd7);
    check("com_winner", 32'(winner), 32'd1);
    check("com_over", 32'(match_over), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 100);
    step(1'b1, 1'b0, 1'b0, 1'b1, 100);
    check("over_frozen", 32'(p2_score), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 100);
    check("restart_p1", 32'(p1_score), 32'd0);
    check("restart_winner", 32'(winner), 32'd0);

    // Saturating threshold from a high base
    step(1'b0, 1'b0, 1'b0, 1'b0, 500);
    step(1'b1, 1'b1, 1'b0, 1'b0, 500);
    wait_play(500, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 500);
      if (i < 2) wait_play(500, 1'b0);
    end
    check("diff_saturate", 32'(difficulty), 32'd511);
    check("hold_p2", 32'(p2_score), 32'd3);

    // Reset during hold
    step(1'b1, 1'b0, 1'b0, 1'b0, 500);
    step(1'b0, 1'b0, 1'b0, 1'b0, 200);
    check("abort_p2", 32'(p2_score), 32'd0);
    check("abort_play_en", 32'(play_en), 32'd0);
    check("abort_diff", 32'(difficulty), 32'd200);
    step(1'b1, 1'b0, 1'b0, 1'b0, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
